// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch tick counter.
// The saturation value is the packed BCD image of MAX_MIN:59.99.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      SAT    = 2'd3
   } sw_state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_NINE     = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   // Packed as {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}.
   function automatic logic [23:0] sat_value(input int unsigned max_min);
      bcd_t tens;
      bcd_t ones;
      tens = bcd_t'(max_min / 10);
      ones = bcd_t'(max_min % 10);
      return {tens, ones, SEC_TENS_MAX, BCD_NINE, BCD_NINE, BCD_NINE};
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MOD-1; carry is combinational so six of these
// chain into a single-cycle ripple increment.
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter int unsigned MOD = 10
)
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output bcd_t digit,
   output logic carry
);

   localparam bcd_t LAST = bcd_t'(MOD - 1);

   assign carry = inc & (digit == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         digit <= '0;
      end else if (inc) begin
         digit <= (digit == LAST) ? '0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_tick_counter.sv
// BCD stopwatch (mm:ss.cc) advanced by rising edges of the 10 ms divider wave,
// sampled as data on clk. Define STOPWATCH_LAP_EN to add the lap/snapshot display.
//
// state  | meaning
// IDLE   | digits zero, waiting for start_stop
// RUN    | counting on tick_pulse
// PAUSED | digits held, start_stop resumes
// SAT    | held at MAX_MIN:59.99, overflow high, only clear/rst leave
module stopwatch_tick_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_MIN = 99
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       start_stop,
   input  logic       clear,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap,
   output logic       lap_active,
`endif
   output logic [7:0] cs_bcd,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic       running,
   output logic       overflow,
   output logic       tick_pulse
);

   localparam logic [23:0] SAT_VAL = sat_value(MAX_MIN);

   sw_state_e   state_q;
   sw_state_e   state_d;
   logic        tick_q;
   logic        tick_armed;
   logic        adv;
   logic        at_max;
   logic [23:0] live;
   logic [23:0] shown;

   bcd_t cs0, cs1, s0, s1, m0, m1;
   logic c_cs0, c_cs1, c_s0, c_s1, c_m0;
   logic min_tens_carry_unused;

   // tick_armed blocks the first sample after reset so a wave that is already
   // high when reset releases is not mistaken for a fresh rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q     <= 1'b0;
         tick_armed <= 1'b0;
         tick_pulse <= 1'b0;
      end else begin
         tick_q     <= tick_in;
         tick_armed <= tick_armed | ~tick_in;
         tick_pulse <= tick_in & ~tick_q & tick_armed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         running  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         running  <= (state_d == RUN);
         overflow <= (state_d == SAT);
      end
   end

   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_stop) state_d = RUN;
         end
         RUN: begin
            if (tick_pulse && at_max) begin
               state_d = SAT;
            end else begin
               adv = tick_pulse;
               if (start_stop) state_d = PAUSED;
            end
         end
         PAUSED: begin
            if (start_stop) state_d = RUN;
         end
         SAT: begin
            state_d = SAT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clear) begin
         state_d = IDLE;
         adv     = 1'b0;
      end
   end

   bcd_digit #(.MOD(10)) u_cs0 (
      .clk(clk), .rst(rst), .clr(clear), .inc(adv),   .digit(cs0), .carry(c_cs0)
   );
   bcd_digit #(.MOD(10)) u_cs1 (
      .clk(clk), .rst(rst), .clr(clear), .inc(c_cs0), .digit(cs1), .carry(c_cs1)
   );
   bcd_digit #(.MOD(10)) u_s0 (
      .clk(clk), .rst(rst), .clr(clear), .inc(c_cs1), .digit(s0),  .carry(c_s0)
   );
   bcd_digit #(.MOD(6)) u_s1 (
      .clk(clk), .rst(rst), .clr(clear), .inc(c_s0),  .digit(s1),  .carry(c_s1)
   );
   bcd_digit #(.MOD(10)) u_m0 (
      .clk(clk), .rst(rst), .clr(clear), .inc(c_s1),  .digit(m0),  .carry(c_m0)
   );
   // Saturation stops the count before minutes could ever pass MAX_MIN.
   bcd_digit #(.MOD(10)) u_m1 (
      .clk(clk), .rst(rst), .clr(clear), .inc(c_m0),  .digit(m1),  .carry(min_tens_carry_unused)
   );

   assign live   = {m1, m0, s1, s0, cs1, cs0};
   assign at_max = (live == SAT_VAL);

`ifdef STOPWATCH_LAP_EN
   logic [23:0] snap;

   always_ff @(posedge clk) begin
      if (rst) begin
         lap_active <= 1'b0;
         snap       <= '0;
      end else if (state_d != RUN) begin
         lap_active <= 1'b0;
      end else if (lap && state_q == RUN) begin
         lap_active <= ~lap_active;
         if (!lap_active) snap <= live;
      end
   end

   assign shown = lap_active ? snap : live;
`else
   assign shown = live;
`endif

   assign min_bcd = shown[23:16];
   assign sec_bcd = shown[15:8];
   assign cs_bcd  = shown[7:0];

endmodule

// File: doc/stopwatch_tick_counter.md
Name: stopwatch_tick_counter

Overview:
- Consumer end of the 10 ms divided-clock interface.
- Takes the slow square wave from the clock divider as a plain data input (never as a clock), all logic on the system clock `clk`.
- Rising edges of that wave become single-cycle enables that advance a BCD stopwatch (minutes:seconds.centiseconds) under start/stop/clear control.
- Outputs feed the display/segment driver.

Parameters:
- MAX_MIN, 99, highest minute value; legal range 1..99. Count saturates at MAX_MIN:59.99.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous active-high reset.
- tick_in  input  1  10 ms square wave from the divider; sampled as data.
- start_stop  input  1  one-cycle pulse; toggles run/pause.
- clear  input  1  one-cycle pulse; returns to zero/IDLE.
- cs_bcd  output  8  centiseconds, two BCD digits, 00..99.
- sec_bcd  output  8  seconds, two BCD digits, 00..59.
- min_bcd  output  8  minutes, two BCD digits, 00..MAX_MIN.
- running  output  1  high in RUN.
- overflow  output  1  high in SAT.
- tick_pulse  output  1  registered one-cycle pulse per tick_in rising edge; debug/chaining.

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset is synchronous and active-high on `rst`.
  - On rst: all digits 0, running=0, overflow=0, tick_pulse=0, tick_q=0, state=IDLE.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - tick_pulse <= tick_in & ~tick_q, so tick_pulse is high one cycle after the sampled rising edge.
  - Falling edges are ignored.
  - tick_pulse is generated in every state; it only advances the count in RUN.
- Count update:
  - On a cycle where tick_pulse=1 and state=RUN, the digits update at the same clock edge; count is visible 2 cycles after the tick_in rise.
- BCD arithmetic: each digit is 4 bits.
  - cs low digit wraps 9->0 with carry; cs high digit wraps 9->0 with carry into seconds.
  - sec low digit wraps 9->0; sec high digit wraps 5->0 with carry into minutes.
  - min digits count 00..MAX_MIN.
  - No binary-to-BCD conversion.
- States:
  - IDLE: digits 0. start_stop -> RUN.
  - RUN: count on tick_pulse. start_stop -> PAUSED.
  - PAUSED: digits hold. start_stop -> RUN.
  - SAT: digits hold at MAX_MIN:59.99, overflow=1. start_stop ignored.
  - clear from any state -> IDLE with digits zeroed next cycle.
- Saturation: in RUN, a tick_pulse while the count is MAX_MIN:59.99 -> SAT; digits do not wrap.
- Simultaneous events:
  - clear beats everything.
  - tick_pulse + start_stop in RUN: the tick is counted AND state -> PAUSED.
  - tick_pulse + start_stop in PAUSED: the tick is not counted; state -> RUN.
  - tick_pulse + start_stop in IDLE: digits stay 0; state -> RUN.
  - Final tick + start_stop at MAX_MIN:59.99: SAT wins.
- Mid-operation rst: identical to power-on reset, regardless of state or tick phase.
- Output registering: running and overflow are registered decodes of the next state and change in the same cycle as the state.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input `lap` (1-bit pulse) and output `lap_active` (1).
  - A lap pulse in RUN snapshots the live digits; cs/sec/min_bcd then show the snapshot while the internal count continues; lap_active=1.
  - A second lap pulse, or leaving RUN (pause, SAT or clear), releases: outputs track the live count next cycle and lap_active=0.
  - lap is ignored outside RUN.
  - clear same cycle as lap: clear wins.
- Undefined: no lap port, no lap_active port, no snapshot registers; outputs are always the live count.

Decomposition:
- Package stopwatch_pkg:
  - state enum: IDLE, RUN, PAUSED, SAT.
  - BCD digit typedef (4 bits).
  - constants BCD_NINE=9, SEC_TENS_MAX=5.
  - function for the saturation-compare value derived from MAX_MIN.
- Sub-module bcd_digit: parameter MOD; inputs clk, rst, clr, inc; outputs digit[3:0] and carry (inc & digit==MOD-1). Instantiated six times.
- FSM and edge detect stay in the top level.

Test Plan:
- Reset then start_stop pulse, tick_in toggled every 5 clk, 100 rising edges -> cs=00, sec=01, min=00, running=1; tick_pulse count=100.
- Run to 00:59.99 then one tick -> 01:00.00. Also check 00:09.99 -> 00:10.00.
- start_stop coincident with tick_pulse in RUN -> digits +1, running=0. start_stop coincident with tick_pulse in PAUSED -> no increment, running=1.
- MAX_MIN=2, preload via run to 02:59.99, one more tick -> holds 02:59.99, overflow=1; start_stop ignored; clear -> 00:00.00, overflow=0, IDLE.
- rst asserted mid-RUN at 00:37.42 with tick_in high -> all outputs 0 next cycle; no spurious tick_pulse while tick_in stays high after release.
- STOPWATCH_LAP_EN defined: lap at 00:05.00, run 300 ticks -> outputs stay 00:05.00, lap_active=1; second lap -> 00:08.00.
